// File: rtl/alu_sequencer.sv
// alu_sequencer: buffers ALU commands and strobes a 4-bit ALU one command at a time.
// Define ALU_SEQ_CHECK_EN to add a golden result model and the rsp_mismatch output.
module alu_sequencer #(
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [1:0] cmd_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_opcode,
  output logic       alu_enable,
  input  logic [7:0] alu_out,
  input  logic       alu_done,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [1:0] rsp_op,
  output logic       rsp_err,
`ifdef ALU_SEQ_CHECK_EN
  output logic       rsp_mismatch,
`endif
  output logic       busy
);
  localparam int AW = $clog2(CMD_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_WAIT, S_RESP
  } state_t;

  logic [9:0]    mem_q [CMD_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop, full, empty;
  logic [9:0]    head;

  state_t        state_q, state_d;
  logic [3:0]    a_q, a_d, b_q, b_d;
  logic [1:0]    op_q, op_d;
  logic          en_q, en_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          rv_q, rv_d;
  logic [7:0]    data_q, data_d;
  logic [1:0]    rop_q, rop_d;
  logic          err_q, err_d;
  logic          wait_to;

  assign full    = cnt_q == CW'(CMD_DEPTH);
  assign empty   = cnt_q == '0;
  assign push    = cmd_valid && !full;
  assign pop     = (state_q == S_IDLE) && !empty;
  assign head    = mem_q[rd_ptr_q];
  assign wait_to = tmr_q == TW'(TIMEOUT - 1);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage holds data only; validity lives in the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_b, cmd_a};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    en_d    = 1'b0;
    tmr_d   = tmr_q;
    rv_d    = rv_q;
    data_d  = data_q;
    rop_d   = rop_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          a_d     = head[3:0];
          b_d     = head[7:4];
          op_d    = head[9:8];
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        en_d    = 1'b1;
        state_d = S_STROBE;
      end
      S_STROBE: begin
        tmr_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tmr_d = tmr_q + TW'(1);
        if (alu_done) begin
          data_d  = alu_out;
          err_d   = 1'b0;
          rop_d   = op_q;
          rv_d    = 1'b1;
          state_d = S_RESP;
        end else if (wait_to) begin
          data_d  = 8'h00;
          err_d   = 1'b1;
          rop_d   = op_q;
          rv_d    = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rv_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      en_q     <= 1'b0;
      tmr_q    <= '0;
      rv_q     <= 1'b0;
      data_q   <= '0;
      rop_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      en_q     <= en_d;
      tmr_q    <= tmr_d;
      rv_q     <= rv_d;
      data_q   <= data_d;
      rop_q    <= rop_d;
      err_q    <= err_d;
    end
  end

  assign cmd_ready  = !full;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_opcode = op_q;
  assign alu_enable = en_q;
  assign rsp_valid  = rv_q;
  assign rsp_data   = data_q;
  assign rsp_op     = rop_q;
  assign rsp_err    = err_q;
  assign busy       = (state_q != S_IDLE) || !empty;

`ifdef ALU_SEQ_CHECK_EN
  logic [7:0] exp_res;
  logic       mm_q, mm_d;

  always_comb begin
    unique case (op_q)
      2'b00:   exp_res = {4'b0, a_q} + {4'b0, b_q};
      2'b01:   exp_res = {4'b0, a_q} - {4'b0, b_q};
      2'b10:   exp_res = {4'b0, a_q} * {4'b0, b_q};
      default: exp_res = {4'b0, a_q} + 8'd1;
    endcase
    mm_d = mm_q;
    if (state_q == S_WAIT) begin
      if (alu_done) mm_d = alu_out != exp_res;
      else if (wait_to) mm_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mm_q <= 1'b0;
    else     mm_q <= mm_d;
  end

  assign rsp_mismatch = mm_q;
`endif
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: table vectors plus corner sequences, checked through a
// response scoreboard fed at command acceptance.
module tb_alu_sequencer;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_a = '0;
  logic [3:0] cmd_b = '0;
  logic [1:0] cmd_op = '0;
  logic [3:0] alu_a, alu_b;
  logic [1:0] alu_opcode;
  logic       alu_enable;
  logic [7:0] alu_out;
  logic       alu_done;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic [1:0] rsp_op;
  logic       rsp_err;
  logic       busy;
`ifdef ALU_SEQ_CHECK_EN
  logic       rsp_mismatch;
`endif

  alu_sequencer #(.CMD_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_enable(alu_enable), .alu_out(alu_out), .alu_done(alu_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_op(rsp_op), .rsp_err(rsp_err),
`ifdef ALU_SEQ_CHECK_EN
    .rsp_mismatch(rsp_mismatch),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic [1:0] op;
    logic       err;
    logic       mm;
  } rsp_t;

  vec_t vecs[9];
  rsp_t sbq[$];
  int   rsp_cycs[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   pulse_cnt = 0;
  int   exp_pulses = 0;
  int   width_bad = 0;
  logic en_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] golden(input logic [3:0] a,
                                        input logic [3:0] b,
                                        input logic [1:0] op);
    case (op)
      2'b00:   return 8'(a) + 8'(b);
      2'b01:   return 8'(a) - 8'(b);
      2'b10:   return 8'(a) * 8'(b);
      default: return 8'(a) + 8'd1;
    endcase
  endfunction

  // Strobe-driven ALU: result and done land on the edge that sees enable high;
  // done is left high afterwards.
  logic [7:0] m_out = '0;
  logic       m_done = 1'b0;
  logic       done_kill = 1'b0;
  logic       force07 = 1'b0;
  assign alu_out  = m_out;
  assign alu_done = m_done & ~done_kill;

  always @(posedge clk) begin
    if (alu_enable) begin
      m_out  <= force07 ? 8'h07 : golden(alu_a, alu_b, alu_opcode);
      m_done <= 1'b1;
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (alu_enable && en_prev) width_bad++;
    en_prev = alu_enable;
  end

  always @(posedge alu_enable) pulse_cnt++;

  rsp_t       mon_e;
  logic       hold_prev = 1'b0;
  logic [7:0] hd_data;
  logic [1:0] hd_op;
  logic       hd_err;

  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (rsp_valid && hold_prev) begin
        check("hold_data", rsp_data, hd_data);
        check("hold_op", rsp_op, hd_op);
        check("hold_err", rsp_err, hd_err);
      end
      if (rsp_valid && rsp_ready) begin
        check("rsp_expected", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          mon_e = sbq.pop_front();
          check("rsp_data", rsp_data, mon_e.data);
          check("rsp_op", rsp_op, mon_e.op);
          check("rsp_err", rsp_err, mon_e.err);
`ifdef ALU_SEQ_CHECK_EN
          check("rsp_mismatch", rsp_mismatch, mon_e.mm);
`endif
          rsp_cycs.push_back(cyc);
        end
      end
      hold_prev = rsp_valid && !rsp_ready;
      hd_data   = rsp_data;
      hd_op     = rsp_op;
      hd_err    = rsp_err;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [3:0] a, input logic [3:0] b,
                          input logic [1:0] op, input logic [7:0] exp,
                          input logic err, input logic mm,
                          output int waited);
    rsp_t e;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!cmd_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    check("cmd_accept", cmd_ready, 1);
    if (cmd_ready) begin
      @(posedge clk);
      e.data = exp; e.op = op; e.err = err; e.mm = mm;
      sbq.push_back(e);
      exp_pulses++;
      #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while ((busy || sbq.size() != 0) && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check(name, busy || sbq.size() != 0, 0);
    step(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_alu_a"}, alu_a, 0);
    check({tag, "_alu_b"}, alu_b, 0);
    check({tag, "_alu_opcode"}, alu_opcode, 0);
    check({tag, "_alu_enable"}, alu_enable, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_rsp_op"}, rsp_op, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_busy"}, busy, 0);
`ifdef ALU_SEQ_CHECK_EN
    check({tag, "_mismatch"}, rsp_mismatch, 0);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    vecs[0] = '{4'd4,  4'd2, 2'b00, 8'h06};
    vecs[1] = '{4'd4,  4'd2, 2'b01, 8'h02};
    vecs[2] = '{4'd2,  4'd4, 2'b01, 8'hFE};
    vecs[3] = '{4'd15, 4'd15, 2'b10, 8'hE1};
    vecs[4] = '{4'd15, 4'd7, 2'b11, 8'h10};
    vecs[5] = '{4'd15, 4'd15, 2'b00, 8'h1E};
    vecs[6] = '{4'd0,  4'd9, 2'b10, 8'h00};
    vecs[7] = '{4'd0,  4'd3, 2'b11, 8'h01};
    vecs[8] = '{4'd0,  4'd1, 2'b01, 8'hFF};

    step(2);
    check_reset_outputs("reset");
    rst = 1'b0;
    step(1);

    // Single add, cycle-exact latency
    push_cmd(vecs[0].a, vecs[0].b, vecs[0].op, vecs[0].exp, 1'b0, 1'b0, w);
    step(1);
    check("setup_a", alu_a, 4'd4);
    check("setup_b", alu_b, 4'd2);
    check("setup_op", alu_opcode, 2'b00);
    check("setup_en", alu_enable, 0);
    check("setup_busy", busy, 1);
    step(1);
    check("strobe_en", alu_enable, 1);
    step(1);
    check("wait_en", alu_enable, 0);
    check("wait_rv", rsp_valid, 0);
    step(1);
    check("resp_rv", rsp_valid, 1);
    check("resp_data", rsp_data, 8'h06);
    check("resp_err", rsp_err, 0);
    check("resp_hold_a", alu_a, 4'd4);
    wait_idle("single_drain");

    // Back-to-back table vectors, responses 5 cycles apart
    rsp_cycs.delete();
    for (int i = 1; i < 9; i++) begin
      push_cmd(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, 1'b0, 1'b0, w);
      if (i <= 4) check("b2b_ready", w, 0);
    end
    wait_idle("table_drain");
    check("table_rsp_count", rsp_cycs.size(), 8);
    for (int i = 1; i < rsp_cycs.size(); i++)
      check("table_spacing", rsp_cycs[i] - rsp_cycs[i-1], 5);

    // FIFO full under response backpressure
    rsp_ready = 1'b0;
    for (int i = 1; i < 6; i++) begin
      push_cmd(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, 1'b0, 1'b0, w);
      check("full_accept_wait", w, 0);
    end
    check("full_ready", cmd_ready, 0);
    step(3);
    check("full_ready_held", cmd_ready, 0);
    check("full_rv_held", rsp_valid, 1);
    rsp_ready = 1'b1;
    wait_idle("full_drain");

    // Timeout with done held low
    done_kill = 1'b1;
    push_cmd(4'd3, 4'd5, 2'b00, 8'h00, 1'b1, 1'b0, w);
    step(TMO + 2);
    check("tmo_early", rsp_valid, 0);
    step(1);
    check("tmo_rv", rsp_valid, 1);
    check("tmo_err", rsp_err, 1);
    check("tmo_data", rsp_data, 0);
    wait_idle("tmo_drain");
    done_kill = 1'b0;

    // Wrong ALU result passes through; checker flags it
    force07 = 1'b1;
    push_cmd(4'd4, 4'd2, 2'b00, 8'h07, 1'b0, 1'b1, w);
    wait_idle("force_drain");
    force07 = 1'b0;

    // Asynchronous reset during STROBE flushes everything
    for (int i = 5; i < 8; i++)
      push_cmd(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, 1'b0, 1'b0, w);
    check("pre_rst_strobe", alu_enable, 1);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    sbq.delete();
    exp_pulses -= 2;
    step(1);
    rst = 1'b0;
    step(20);
    check("post_rst_busy", busy, 0);
    check("post_rst_rv", rsp_valid, 0);
    push_cmd(vecs[0].a, vecs[0].b, vecs[0].op, vecs[0].exp, 1'b0, 1'b0, w);
    wait_idle("recover_drain");

    check("pulse_count", pulse_cnt, exp_pulses);
    check("pulse_width", width_bad, 0);
    check("sb_empty", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
